// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver using 8x oversampling.
// Each bit is decided by a majority vote of the samples at indices 3, 4 and 5.
// Reception ends on stop-bit sample 5, so a back-to-back start bit is not missed.
module uart_rx_os #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = clk_freq / (baud_rate * 8);
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t        r_state;
  logic          r_sync0;
  logic          r_sync1;
  logic          r_rx_prev;
  logic [DW-1:0] r_div;
  logic [2:0]    r_sidx;
  logic [2:0]    r_bitcnt;
  logic          r_s3;
  logic          r_s4;
  logic [7:0]    r_shift;
  logic [7:0]    r_dout;
  logic          r_done;
  logic          r_ferr;
  logic          r_busy;

  logic w_rx_s;
  logic w_fall;
  logic w_tick;
  logic w_vote;

  assign w_rx_s = r_sync1;
  assign w_fall = r_rx_prev & ~w_rx_s;
  assign w_tick = (r_div == DIV_LAST);
  // The vote is only consumed on the tick at sample index 5.
  assign w_vote = maj3(r_s3, r_s4, w_rx_s);

  assign dout      = r_dout;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

  // Synchronizer, oversample divider, and the receive state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync0   <= 1'b1;
      r_sync1   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_div     <= '0;
      r_sidx    <= 3'd0;
      r_bitcnt  <= 3'd0;
      r_s3      <= 1'b0;
      r_s4      <= 1'b0;
      r_shift   <= 8'h00;
      r_dout    <= 8'h00;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync0   <= rx;
      r_sync1   <= r_sync0;
      r_rx_prev <= w_rx_s;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;

      if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end

      // Sample counter and the two stored samples ahead of the vote.
      if (w_tick && (r_state != S_IDLE)) begin
        r_sidx <= r_sidx + 3'd1;
        if (r_sidx == 3'd3) begin
          r_s3 <= w_rx_s;
        end
        if (r_sidx == 3'd4) begin
          r_s4 <= w_rx_s;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_div    <= '0;
            r_sidx   <= 3'd0;
            r_bitcnt <= 3'd0;
            r_state  <= S_START;
            r_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if ((r_sidx == 3'd5) && w_vote) begin
              // The low level did not last: treat it as a glitch.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (r_sidx == 3'd7) begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_sidx == 3'd5) begin
              r_shift <= {w_vote, r_shift[7:1]};
            end
            if (r_sidx == 3'd7) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_state <= S_STOP;
              end
            end
          end
        end
        S_STOP: begin
          // Leave at sample index 5 so the next start edge can be seen.
          if (w_tick && (r_sidx == 3'd5)) begin
            if (w_vote) begin
              r_dout <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os.
// A frame-level model runs alongside the DUT and is compared with it on every cycle.
// Hand-computed expectations are checked after each scenario.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int DIV  = 13;
  localparam int BIT9600 = 104167;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       busy;

  uart_rx_os #(.clk_freq(1000000), .baud_rate(9600)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .dout(dout), .done(done), .frame_err(frame_err), .busy(busy)
  );

  always #500 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pin value seen at each rising edge; reset cycles are recorded as 1,
  // because the synchronizer is held at 1 while reset is active.
  bit         hist [0:65535];
  int         cyc = 0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  bit         m_ferr = 1'b0;
  logic [7:0] m_dout = 8'h00;
  int         k0 = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  int         last_done_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit maj(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Frame bit b (0 = start, 1..8 = data, 9 = stop). The receiver sees the pin
  // two cycles late. Its samples fall on ticks 8b+4, 8b+5 and 8b+6 after start detection.
  function automatic bit vote(input int b);
    int base;
    base = k0 + DIV * 8 * b - 2;
    return maj(hist[base + DIV*4], hist[base + DIV*5], hist[base + DIV*6]);
  endfunction

  // Model update on each rising edge, compare on the following falling edge.
  initial begin
    bit cur_rx;
    bit cur_rst;
    int d;
    forever begin
      @(posedge clk);
      cyc++;
      cur_rx  = rx;
      cur_rst = rst;
      m_done  = 1'b0;
      m_ferr  = 1'b0;
      if (cur_rst) begin
        hist[cyc] = 1'b1;
        m_busy = 1'b0;
        m_dout = 8'h00;
      end else begin
        hist[cyc] = cur_rx;
        if (!m_busy) begin
          if (cyc >= 3 && hist[cyc-3] && !hist[cyc-2]) begin
            m_busy = 1'b1;
            k0 = cyc;
          end
        end else begin
          d = cyc - k0;
          if (d == DIV*6 && vote(0)) begin
            m_busy = 1'b0;
          end else if (d == DIV*78) begin
            m_busy = 1'b0;
            if (vote(9)) begin
              m_done = 1'b1;
              for (int n = 0; n < 8; n++) m_dout[n] = vote(n + 1);
            end else begin
              m_ferr = 1'b1;
            end
          end
        end
      end
      @(negedge clk);
      check("done", {31'd0, done}, {31'd0, m_done});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("dout", {24'd0, dout}, {24'd0, m_dout});
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_q.push_back(dout);
      end
      if (frame_err) ferr_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // Drive n line bits, LSB first. Edges land 250 ns after a falling clock edge.
  task automatic send_raw(input logic [19:0] bits, input int n, input int bit_ns);
    @(negedge clk);
    #250;
    fall_cyc = cyc + 1;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      #(bit_ns);
    end
  endtask

  task automatic set_rx(input logic v);
    @(negedge clk);
    #250;
    rx = v;
  endtask

  initial begin
    int d0;
    int f0;
    int b0;
    repeat (5) @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    #100 rst = 1'b0;
    repeat (20) @(negedge clk);

    // A5, nominal baud
    d0 = done_cnt; f0 = ferr_cnt;
    send_raw({10'd0, 1'b1, 8'hA5, 1'b0}, 10, BIT9600);
    repeat (100) @(negedge clk);
    check("a5_done_count", done_cnt - d0, 32'd1);
    check("a5_ferr_count", ferr_cnt - f0, 32'd0);
    check("a5_dout", {24'd0, dout}, 32'hA5);
    check("a5_busy_after", {31'd0, busy}, 32'h0);
    check("a5_latency", last_done_cyc - fall_cyc, 32'd1016);

    // 00 then FF back-to-back
    d0 = done_cnt;
    send_raw({1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20, BIT9600);
    repeat (100) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 32'd2);
    check("b2b_first", {24'd0, done_q[done_q.size()-2]}, 32'h00);
    check("b2b_second", {24'd0, done_q[done_q.size()-1]}, 32'hFF);

    // 3C with a low stop bit, then the line held low (break)
    d0 = done_cnt; f0 = ferr_cnt;
    send_raw({10'd0, 1'b0, 8'h3C, 1'b0}, 10, BIT9600);
    repeat (3000) @(negedge clk);
    set_rx(1'b1);
    repeat (100) @(negedge clk);
    check("brk_ferr_count", ferr_cnt - f0, 32'd1);
    check("brk_done_count", done_cnt - d0, 32'd0);
    check("brk_dout_kept", {24'd0, dout}, 32'hFF);

    // 2 us glitch on an idle line
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    @(negedge clk);
    #250 rx = 1'b0;
    #2000 rx = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_busy_rose", {31'd0, (busy_cnt - b0) > 0}, 32'd1);
    check("glitch_busy_short", {31'd0, (busy_cnt - b0) <= 6*DIV + 3}, 32'd1);
    check("glitch_no_done", done_cnt - d0, 32'd0);
    check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

    // Reset during data bit 4, then 5A
    d0 = done_cnt; f0 = ferr_cnt;
    send_raw({10'd0, 1'b1, 8'h00, 1'b0}, 5, BIT9600);
    rx = 1'b0;
    #52000;
    @(negedge clk);
    #100 rst = 1'b1;
    #150 rx = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_dout", {24'd0, dout}, 32'h0);
    #100 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_abort_no_done", done_cnt - d0, 32'd0);
    send_raw({10'd0, 1'b1, 8'h5A, 1'b0}, 10, BIT9600);
    repeat (100) @(negedge clk);
    check("rst_5a_done", done_cnt - d0, 32'd1);
    check("rst_5a_ferr", ferr_cnt - f0, 32'd0);
    check("rst_5a_dout", {24'd0, dout}, 32'h5A);

    // 81 at -3% and +3% bit period
    d0 = done_cnt;
    send_raw({10'd0, 1'b1, 8'h81, 1'b0}, 10, 101000);
    repeat (100) @(negedge clk);
    check("fast_done", done_cnt - d0, 32'd1);
    check("fast_dout", {24'd0, dout}, 32'h81);
    set_rx(1'b1);
    @(negedge clk);
    #100 rst = 1'b1;
    repeat (2) @(negedge clk);
    #100 rst = 1'b0;
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    send_raw({10'd0, 1'b1, 8'h81, 1'b0}, 10, 107000);
    repeat (100) @(negedge clk);
    check("slow_done", done_cnt - d0, 32'd1);
    check("slow_dout", {24'd0, dout}, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The module SHALL have parameter clk_freq, default 1000000, meaning system clock frequency in Hz.
REQ-002 The module SHALL have parameter baud_rate, default 9600, meaning serial bit rate in baud.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the system clock, rising-edge active, and rst input 1 is the reset.
REQ-004 The module SHALL have rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The module SHALL have dout, output, 8 bits: last correctly framed byte received.
REQ-006 The module SHALL have done, output, 1 bit: one-cycle pulse, valid byte on dout.
REQ-007 The module SHALL have frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-008 The module SHALL have busy, output, 1 bit: high whenever a frame is in progress (state not IDLE).

Function
REQ-009 The frame SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-010 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-011 The oversample tick SHALL be 8x baud: DIV = clk_freq/(baud_rate*8), integer division (13 at defaults), and tick pulses one cycle every DIV clocks.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL clear the tick divider and sample counter and enter START in the same cycle. No edge means no action.
REQ-014 In each bit, a 3-bit sample counter SHALL advance on every tick. The bit value is the majority of rx_s at sample indices 3, 4 and 5. The bit ends on the tick at index 7.
REQ-015 START: if the vote is 1 (false start/glitch), the block SHALL return to IDLE at index 5 with no output pulse. Otherwise it enters DATA at the end of the bit.
REQ-016 DATA: each voted bit SHALL shift into a shift register MSB-side, so the first received bit lands in bit 0. After 8 bits, go to STOP.
REQ-017 STOP: at index 5, vote 1 SHALL load dout with the byte, pulse done for exactly 1 cycle and return to IDLE.
REQ-018 STOP: at index 5, vote 0 SHALL pulse frame_err for 1 cycle, leave dout unchanged and return to IDLE.
REQ-019 Latency SHALL be fixed: done/frame_err asserts the cycle after the 78th tick following start detection. That is 78*DIV = 1014 clocks at defaults, or 1016-1017 clocks after the rx pin falls.
REQ-020 Leaving STOP at index 5 SHALL allow a start bit immediately following the stop bit (back-to-back frames) to be detected with no lost frame.
REQ-021 A break (rx held 0 past the stop bit) SHALL produce a single frame_err and no further frames until rx_s returns to 1 and falls again.
REQ-022 done and frame_err SHALL never assert in the same cycle.
REQ-023 dout SHALL hold its value between successful frames.

Reset
REQ-024 While rst=1, the block SHALL hold state=IDLE, dout=8'h00, done=0, frame_err=0, busy=0, both synchronizer flops=1, and all counters=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no done/frame_err pulse. After release, reception resumes only on a new falling edge.

Verification
REQ-026 Send 8'hA5 as valid 8N1 at 9600 baud (104.17 us/bit, clk 1 MHz) -> a single done pulse, dout=8'hA5, frame_err never high, busy low afterwards.
REQ-027 Send 8'h00 then 8'hFF back-to-back with no idle gap -> two done pulses; dout=8'h00 after the first and 8'hFF after the second.
REQ-028 Send 8'h3C with the stop bit driven 0 -> frame_err pulses once, done stays 0, dout keeps its previous value.
REQ-029 Apply a 2 us low glitch on idle rx -> busy rises then returns low within 6*DIV+3 clocks; no done and no frame_err.
REQ-030 Assert rst during data bit 4 of a frame, then send 8'h5A -> no pulse for the aborted frame; 8'h5A is received correctly.
REQ-031 Send 8'h81 at baud +/-3% (bit period 101/107 us) -> dout=8'h81 with a done pulse in both cases.
